// File: rtl/raster_pkg.sv
// Shared raster constants and coordinate types for the display path (default VGA 640x480, totals 800x525).
package raster_pkg;
  localparam int VGA_X_BITS   = 10;
  localparam int VGA_Y_BITS   = 10;
  localparam int VGA_X_TOTAL  = 800;
  localparam int VGA_Y_TOTAL  = 525;
  localparam int VGA_X_ACTIVE = 640;
  localparam int VGA_Y_ACTIVE = 480;

  typedef logic [VGA_X_BITS-1:0] x_t;
  typedef logic [VGA_Y_BITS-1:0] y_t;
endpackage

// File: rtl/mod_counter.sv
// Wrapping modulo-MODULUS counter with synchronous clear and terminal-count flag.
// Latency: count updates on the edge sampling enable; at_max is combinational from count.
// Backpressure: none; enable low holds the count.
module mod_counter #(
  parameter int WIDTH   = 10,
  parameter int MODULUS = 800
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  assign at_max = (count == MAX);

  // Wrap is explicit so MODULUS == 2**WIDTH never relies on overflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= at_max ? '0 : count + WIDTH'(1);
    end
  end
endmodule

// File: rtl/raster_counter.sv
// Two-dimensional scan counter (x cascaded into y) with frame count and active/line/frame flags.
// Latency: x/y/frame update one edge after enable is sampled; flags are combinational from x/y.
// Backpressure: none; enable low freezes position, frame and flags.
module raster_counter
  import raster_pkg::*;
#(
  parameter int X_BITS     = VGA_X_BITS,
  parameter int Y_BITS     = VGA_Y_BITS,
  parameter int X_TOTAL    = VGA_X_TOTAL,
  parameter int Y_TOTAL    = VGA_Y_TOTAL,
  parameter int X_ACTIVE   = VGA_X_ACTIVE,
  parameter int Y_ACTIVE   = VGA_Y_ACTIVE,
  parameter int FRAME_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clear,
  output logic [X_BITS-1:0]     x,
  output logic [Y_BITS-1:0]     y,
  output logic [FRAME_BITS-1:0] frame,
  output logic                  active,
  output logic                  line_end,
  output logic                  frame_end
);
  if (X_TOTAL < 2 || Y_TOTAL < 2) begin : g_err_total_min
    $error("raster_counter: X_TOTAL and Y_TOTAL must be at least 2");
  end
  if (X_TOTAL > 2**X_BITS || Y_TOTAL > 2**Y_BITS) begin : g_err_total_width
    $error("raster_counter: totals do not fit in X_BITS/Y_BITS");
  end
  if (X_ACTIVE > X_TOTAL || Y_ACTIVE > Y_TOTAL) begin : g_err_active_max
    $error("raster_counter: active region exceeds totals");
  end
  if (X_ACTIVE == 0 || Y_ACTIVE == 0) begin : g_err_active_zero
    $error("raster_counter: active region must be non-empty");
  end

  // One extra bit so an active width equal to 2**X_BITS is representable.
  localparam logic [X_BITS:0] XA = (X_BITS + 1)'(X_ACTIVE);
  localparam logic [Y_BITS:0] YA = (Y_BITS + 1)'(Y_ACTIVE);

  logic x_at_max;
  logic y_at_max;

  mod_counter #(.WIDTH(X_BITS), .MODULUS(X_TOTAL)) u_x (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .clear  (clear),
    .count  (x),
    .at_max (x_at_max)
  );

  mod_counter #(.WIDTH(Y_BITS), .MODULUS(Y_TOTAL)) u_y (
    .clk    (clk),
    .rst    (rst),
    .enable (enable && x_at_max),
    .clear  (clear),
    .count  (y),
    .at_max (y_at_max)
  );

  assign line_end  = x_at_max;
  assign frame_end = x_at_max && y_at_max;
  assign active    = ({1'b0, x} < XA) && ({1'b0, y} < YA);

  // Frame count survives clear; only reset zeroes it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame <= '0;
    end else if (!clear && enable && frame_end) begin
      frame <= frame + FRAME_BITS'(1);
    end
  end
endmodule

// File: tb/tb_raster_counter.sv
// Bench for raster_counter in a 5x3 configuration against a linear-position reference model.
module tb_raster_counter;
  localparam int XB = 3;
  localparam int YB = 2;
  localparam int FB = 2;
  localparam int XT = 5;
  localparam int YT = 3;
  localparam int XA = 4;
  localparam int YA = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic [XB-1:0] x;
  logic [YB-1:0] y;
  logic [FB-1:0] frame;
  logic          active;
  logic          line_end;
  logic          frame_end;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: scan position as a single index into the frame, plus a frame count.
  int pos = 0;
  int frm = 0;

  raster_counter #(
    .X_BITS(XB), .Y_BITS(YB), .X_TOTAL(XT), .Y_TOTAL(YT),
    .X_ACTIVE(XA), .Y_ACTIVE(YA), .FRAME_BITS(FB)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .x(x), .y(y), .frame(frame),
    .active(active), .line_end(line_end), .frame_end(frame_end)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int ex, ey;
    ex = pos % XT;
    ey = pos / XT;
    check("x", 32'(x), ex);
    check("y", 32'(y), ey);
    check("frame", 32'(frame), frm);
    check("active", 32'(active), (ex < XA && ey < YA) ? 1 : 0);
    check("line_end", 32'(line_end), (ex == XT - 1) ? 1 : 0);
    check("frame_end", 32'(frame_end), (pos == XT * YT - 1) ? 1 : 0);
  endtask

  // Called at a falling edge: drive, clock, update model, sample at next falling edge.
  task automatic step(input logic r, input logic c, input logic e);
    rst    = r;
    clear  = c;
    enable = e;
    @(posedge clk);
    if (!r) begin
      pos = 0;
      frm = 0;
    end else if (c) begin
      pos = 0;
    end else if (e) begin
      if (pos == XT * YT - 1) begin
        pos = 0;
        frm = (frm + 1) % (1 << FB);
      end else begin
        pos = pos + 1;
      end
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    @(negedge clk);
    // Reset held with enable high
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1);
      check("rst_active", 32'(active), 1);
    end
    // Full scan
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 1'b1);
    check("scan_frame1", 32'(frame), 1);
    // Advance to x=4,y=1 then pause
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0);
      check("pause_line_end", 32'(line_end), 1);
      check("pause_x", 32'(x), 4);
    end
    step(1'b1, 1'b0, 1'b1);
    check("resume_y", 32'(y), 2);
    // Clear with enable at x=3,y=2
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
    check("pre_clear_x", 32'(x), 3);
    step(1'b1, 1'b1, 1'b1);
    check("clear_x", 32'(x), 0);
    check("clear_frame", 32'(frame), 1);
    // Four full frames: frame wraps through 0
    for (int i = 0; i < 60; i++) step(1'b1, 1'b0, 1'b1);
    check("wrap_frame", 32'(frame), 1);
    // Reach frame=2, x=2, y=1 then reset with clear asserted
    for (int i = 0; i < 22; i++) step(1'b1, 1'b0, 1'b1);
    check("pre_rst_frame", 32'(frame), 2);
    check("pre_rst_x", 32'(x), 2);
    step(1'b0, 1'b1, 1'b1);
    check("midrst_frame", 32'(frame), 0);
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(63) != 0), ($urandom_range(15) == 0), ($urandom_range(3) != 0));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/raster_counter.md
# raster_counter

Parametrised two-dimensional scan counter for the display path: a horizontal position counter cascaded into a vertical position counter, plus a frame counter. Generalises the single 8-bit enable/reset counter into configurable width, modulus and cascade. It also adds active-region, end-of-line and end-of-frame flags. It drives the timing generator and the pixel fetch stage, and every downstream stage consumes its x/y.

## Interface
- `X_BITS`, default 10: width of `x`.
- `Y_BITS`, default 10: width of `y`.
- `X_TOTAL`, default 800: horizontal modulus. `x` counts 0..X_TOTAL-1.
- `Y_TOTAL`, default 525: vertical modulus. `y` counts 0..Y_TOTAL-1.
- `X_ACTIVE`, default 640: visible columns, 0..X_ACTIVE-1.
- `Y_ACTIVE`, default 480: visible rows, 0..Y_ACTIVE-1.
- `FRAME_BITS`, default 8: width of `frame`. Wraps modulo 2^FRAME_BITS.

Ports:
- `clk`, in, 1: single clock. All state changes on the rising edge.
- `rst`, in, 1: synchronous, active-low reset. One clock, reset synchronous active-low; sampled only on the rising edge of `clk`.
- `enable`, in, 1: advance one position per cycle while high. Hold all state while low.
- `clear`, in, 1: synchronous restart of scan position. `frame` is kept.
- `x`, out, X_BITS: current column.
- `y`, out, Y_BITS: current row.
- `frame`, out, FRAME_BITS: completed-frame count.
- `active`, out, 1: high when (x < X_ACTIVE) && (y < Y_ACTIVE).
- `line_end`, out, 1: high when x == X_TOTAL-1.
- `frame_end`, out, 1: high when x == X_TOTAL-1 && y == Y_TOTAL-1.

## Operation
- Priority on each rising edge: `rst`==0, then `clear`==1, then `enable`==1, then hold.
- Reset values: x=0, y=0, frame=0, active=1, line_end=0, frame_end=0.
- Clear: x=0 and y=0; `frame` unchanged. Clear with enable=1 in the same cycle yields (0,0), not (1,0).
- Enable, x < X_TOTAL-1: x increments by 1; y unchanged.
- Enable, x == X_TOTAL-1: x wraps to 0 and y steps.
  - y steps by +1.
  - If y == Y_TOTAL-1, y wraps to 0 and `frame` increments, modulo 2^FRAME_BITS.
- Enable low: x, y, frame and all flags hold, including a high `line_end`/`frame_end`.
- Reset mid-frame: next cycle reads reset values regardless of `enable`/`clear`.
- Arithmetic: counters never take values at or above their modulus. No intermediate value exceeds X_BITS/Y_BITS.
- Elaboration-time `$error` if any of these fail:
  - X_TOTAL < 2 or Y_TOTAL < 2.
  - X_TOTAL > 2**X_BITS or Y_TOTAL > 2**Y_BITS.
  - X_ACTIVE > X_TOTAL or Y_ACTIVE > Y_TOTAL.
  - X_ACTIVE == 0 or Y_ACTIVE == 0.

## Timing
- Latency: `x` changes on the edge that samples `enable`=1, so it is visible one cycle after `enable` rises.
- `active`, `line_end` and `frame_end` are pure functions of the current registered x/y and `frame`. They are cycle-aligned with x/y, with no extra pipeline stage.
- Flag durations while enabled:
  - `line_end`: exactly one cycle per line.
  - `frame_end`: exactly one cycle per frame.
- `frame` increments on the edge after the `frame_end` cycle, coincident with x/y returning to (0,0).
- Full frame period with continuous enable: X_TOTAL*Y_TOTAL cycles.

## Structure
- Shared package `raster_pkg` holds:
  - default VGA constants: 640x480, totals 800x525;
  - typedefs `x_t` and `y_t` for the default widths, used by downstream stages.
- Sub-module `mod_counter`, instantiated twice:
  - Parameters `WIDTH` and `MODULUS`.
  - Ports `clk`, `rst` (active-low sync), `enable`, `clear`, `count`, `at_max` (combinational, count == MODULUS-1).
  - The x instance gets `enable`.
  - The y instance gets `enable && x_at_max`.
  - `frame` is a plain wrapping register in the top level.

## Test plan
Small configuration: X_TOTAL=5, Y_TOTAL=3, X_ACTIVE=4, Y_ACTIVE=2, FRAME_BITS=2.
- Reset: hold `rst`=0 for 5 cycles with `enable`=1 -> x=0, y=0, frame=0, active=1, line_end=0, frame_end=0 every cycle.
- Full scan: `enable`=1 for 15 cycles after reset.
  - x sequence 0,1,2,3,4,0…; y steps at every x wrap.
  - `line_end` pulses at cycles 4, 9, 14; `frame_end` only at cycle 14.
  - frame=1 at cycle 15.
  - `active`=0 whenever x==4 or y==2.
- Pause: toggle `enable` low for 3 cycles at x=4, y=1 -> x, y and `line_end`=1 held for 3 cycles. Then resume to x=0, y=2.
- Clear vs enable: assert `clear`=1 and `enable`=1 at x=3, y=2, frame=1 -> next cycle x=0, y=0, frame=1.
- Frame wrap: run 4 full frames (60 cycles) -> frame sequence 1, 2, 3, 0.
- Reset mid-frame: drop `rst` at x=2, y=1, frame=2 with `clear`=1 -> all reset values next cycle, including frame=0.
